multicycle_decoder: RTL and testbench

- Next-generation RV32I control decoder.
- Adds a state machine so loads and stores complete through a data-memory handshake.
- PC increment (incr) stalls until the instruction retires. Illegal encodings are trapped.
- Sits between instruction fetch and the datapath (ALU, register file, data memory port).

---
 rtl/riscv_pkg.sv | 39 +++
 rtl/multicycle_decoder_instr_legal_check.sv | 44 ++++
 rtl/multicycle_decoder.sv | 187 ++++++++++++++++++
 tb/tb_multicycle_decoder.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// ============================================================================
// riscv_pkg : shared RV32I opcodes, control FSM states and ALU op codes
// Rev 1.0
// ============================================================================
`default_nettype none

package riscv_pkg;

  localparam logic [6:0] RALU   = 7'b0110011;
  localparam logic [6:0] IALU   = 7'b0010011;
  localparam logic [6:0] ILOAD  = 7'b0000011;
  localparam logic [6:0] SSTORE = 7'b0100011;

  typedef enum logic [1:0] {
    DECODE    = 2'd0,
    MEM_WAIT  = 2'd1,
    WRITEBACK = 2'd2,
    TRAP      = 2'd3
  } ctrl_state_t;

  // ALU op encoding is {funct3, funct7[5]}
  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_SLL  = 4'b0010;
  localparam logic [3:0] ALU_SLT  = 4'b0100;
  localparam logic [3:0] ALU_SLTU = 4'b0110;
  localparam logic [3:0] ALU_XOR  = 4'b1000;
  localparam logic [3:0] ALU_SRL  = 4'b1010;
  localparam logic [3:0] ALU_SRA  = 4'b1011;
  localparam logic [3:0] ALU_OR   = 4'b1100;
  localparam logic [3:0] ALU_AND  = 4'b1110;

  function automatic logic [3:0] alu_op(input logic [2:0] f3, input logic f7b5);
    return {f3, f7b5};
  endfunction

endpackage

`default_nettype wire

// File: rtl/multicycle_decoder_instr_legal_check.sv
// ============================================================================
// instr_legal_check : combinational opcode/funct3/funct7 legality check
// Rev 1.0
// ============================================================================
`default_nettype none

module instr_legal_check
  import riscv_pkg::*;
#(
  parameter int STRICT_DECODE = 1
) (
  input  logic [6:0] opcode_i,
  input  logic [2:0] funct3_i,
  input  logic [6:0] funct7_i,
  output logic       legal_o
);

  localparam logic LAX = (STRICT_DECODE == 0);

  always_comb begin
    legal_o = 1'b0;
    case (opcode_i)
      RALU:
        legal_o = LAX || (funct7_i == 7'h00) ||
                  ((funct7_i == 7'h20) && ((funct3_i == 3'b000) || (funct3_i == 3'b101)));
      IALU: begin
        case (funct3_i)
          3'b001:  legal_o = LAX || (funct7_i == 7'h00);
          3'b101:  legal_o = LAX || (funct7_i == 7'h00) || (funct7_i == 7'h20);
          default: legal_o = 1'b1;
        endcase
      end
      ILOAD:
        legal_o = LAX || (funct3_i inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
      SSTORE:
        legal_o = LAX || (funct3_i inside {3'b000, 3'b001, 3'b010});
      default:
        legal_o = 1'b0;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/multicycle_decoder.sv
// ============================================================================
// multicycle_decoder : RV32I control decoder with load/store handshake FSM
// Rev 1.0
// ============================================================================
`default_nettype none

module multicycle_decoder
  import riscv_pkg::*;
#(
  parameter int ALUOP_W       = 4,
  parameter int MEM_TIMEOUT   = 15,
  parameter int STRICT_DECODE = 1
) (
  input  logic               clock,
  input  logic               nReset,
  input  logic               instr_valid,
  input  logic [6:0]         opcode,
  input  logic [2:0]         funct3,
  input  logic [6:0]         funct7,
  input  logic               mem_ready,
  input  logic               trap_clr,
  output logic [ALUOP_W-1:0] AluOp,
  output logic               regw,
  output logic               imm,
  output logic               incr,
  output logic               mem_req,
  output logic               mem_we,
  output logic [2:0]         mem_size,
  output logic               wb_sel,
  output logic               illegal,
  output logic               bus_err
);

  localparam int CNT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MEM_TIMEOUT);
  localparam logic TIMEOUT_EN = (MEM_TIMEOUT > 0);

  ctrl_state_t      state_q, state_d;
  logic             is_load_q, is_load_d;
  logic [2:0]       size_q, size_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             illegal_q, illegal_d;
  logic             bus_err_q, bus_err_d;
  logic             legal;

  instr_legal_check #(
    .STRICT_DECODE(STRICT_DECODE)
  ) u_legal (
    .opcode_i(opcode),
    .funct3_i(funct3),
    .funct7_i(funct7),
    .legal_o (legal)
  );

  always_comb begin
    state_d   = state_q;
    is_load_d = is_load_q;
    size_d    = size_q;
    cnt_d     = cnt_q;
    illegal_d = illegal_q;
    bus_err_d = bus_err_q;
    AluOp     = '0;
    regw      = 1'b0;
    imm       = 1'b0;
    incr      = 1'b0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_size  = 3'b000;
    wb_sel    = 1'b0;

    case (state_q)
      DECODE: begin
        if (instr_valid) begin
          if (!legal) begin
            illegal_d = 1'b1;
            state_d   = TRAP;
          end else begin
            case (opcode)
              RALU: begin
                AluOp = ALUOP_W'(alu_op(funct3, funct7[5]));
                regw  = 1'b1;
                incr  = 1'b1;
              end
              IALU: begin
                // Only the shift-right group uses funct7[5] (SRLI vs SRAI)
                AluOp = ALUOP_W'(alu_op(funct3, (funct3 == 3'b101) && funct7[5]));
                imm   = 1'b1;
                regw  = 1'b1;
                incr  = 1'b1;
              end
              ILOAD, SSTORE: begin
                AluOp     = ALUOP_W'(ALU_ADD);
                imm       = 1'b1;
                mem_req   = 1'b1;
                mem_we    = (opcode == SSTORE);
                mem_size  = funct3;
                is_load_d = (opcode == ILOAD);
                size_d    = funct3;
                cnt_d     = '0;
                state_d   = MEM_WAIT;
              end
              default: begin
                illegal_d = 1'b1;
                state_d   = TRAP;
              end
            endcase
          end
        end
      end

      MEM_WAIT: begin
        AluOp    = ALUOP_W'(ALU_ADD);
        imm      = 1'b1;
        mem_req  = 1'b1;
        mem_we   = !is_load_q;
        mem_size = size_q;
        // Completion takes priority over a coincident timeout
        if (mem_ready) begin
          if (is_load_q) begin
            state_d = WRITEBACK;
          end else begin
            incr    = 1'b1;
            state_d = DECODE;
          end
        end else if (TIMEOUT_EN && (cnt_q == CNT_MAX)) begin
          bus_err_d = 1'b1;
          state_d   = TRAP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      WRITEBACK: begin
        regw    = 1'b1;
        wb_sel  = 1'b1;
        incr    = 1'b1;
        state_d = DECODE;
      end

      TRAP: begin
        if (trap_clr) begin
          illegal_d = 1'b0;
          bus_err_d = 1'b0;
          state_d   = DECODE;
        end
      end

      default: state_d = DECODE;
    endcase

    // Outputs stay at their idle values for as long as reset is held
    if (!nReset) begin
      AluOp    = '0;
      regw     = 1'b0;
      imm      = 1'b0;
      incr     = 1'b0;
      mem_req  = 1'b0;
      mem_we   = 1'b0;
      mem_size = 3'b000;
      wb_sel   = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge nReset) begin
    if (!nReset) begin
      state_q   <= DECODE;
      is_load_q <= 1'b0;
      size_q    <= 3'b000;
      cnt_q     <= '0;
      illegal_q <= 1'b0;
      bus_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      is_load_q <= is_load_d;
      size_q    <= size_d;
      cnt_q     <= cnt_d;
      illegal_q <= illegal_d;
      bus_err_q <= bus_err_d;
    end
  end

  assign illegal = illegal_q;
  assign bus_err = bus_err_q;

endmodule

`default_nettype wire

// File: tb/tb_multicycle_decoder.sv
// ============================================================================
// tb_multicycle_decoder : directed scoreboard bench for multicycle_decoder
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_multicycle_decoder;

  localparam logic [6:0] OP_R = 7'b0110011;
  localparam logic [6:0] OP_I = 7'b0010011;
  localparam logic [6:0] OP_L = 7'b0000011;
  localparam logic [6:0] OP_S = 7'b0100011;

  // Packed output vector: {AluOp[14:11], regw, imm, incr, mem_req, mem_we, mem_size[5:3], wb_sel, illegal, bus_err}
  localparam logic [14:0] ALL   = 15'h7FFF;
  localparam logic [14:0] NO_SZ = 15'h7FC7;

  logic       clock = 1'b0;
  logic       nReset = 1'b0;
  logic       nReset_b = 1'b0;
  logic       instr_valid = 1'b0;
  logic [6:0] opcode = '0;
  logic [2:0] funct3 = '0;
  logic [6:0] funct7 = '0;
  logic       mem_ready = 1'b0;
  logic       trap_clr = 1'b0;

  logic [3:0] a_alu, b_alu;
  logic       a_regw, a_imm, a_incr, a_req, a_we, a_wb, a_ill, a_be;
  logic       b_regw, b_imm, b_incr, b_req, b_we, b_wb, b_ill, b_be;
  logic [2:0] a_sz, b_sz;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [14:0] e;
    logic [14:0] m;
    string       tag;
  } exp_t;
  exp_t sb[$];

  always #5 clock = ~clock;

  multicycle_decoder u_a (
    .clock(clock), .nReset(nReset), .instr_valid(instr_valid), .opcode(opcode),
    .funct3(funct3), .funct7(funct7), .mem_ready(mem_ready), .trap_clr(trap_clr),
    .AluOp(a_alu), .regw(a_regw), .imm(a_imm), .incr(a_incr), .mem_req(a_req),
    .mem_we(a_we), .mem_size(a_sz), .wb_sel(a_wb), .illegal(a_ill), .bus_err(a_be)
  );

  multicycle_decoder #(.MEM_TIMEOUT(4)) u_b (
    .clock(clock), .nReset(nReset_b), .instr_valid(instr_valid), .opcode(opcode),
    .funct3(funct3), .funct7(funct7), .mem_ready(mem_ready), .trap_clr(trap_clr),
    .AluOp(b_alu), .regw(b_regw), .imm(b_imm), .incr(b_incr), .mem_req(b_req),
    .mem_we(b_we), .mem_size(b_sz), .wb_sel(b_wb), .illegal(b_ill), .bus_err(b_be)
  );

  function automatic logic [14:0] pk(input logic [3:0] alu, input logic rw, input logic im,
                                     input logic inc, input logic rq, input logic we,
                                     input logic [2:0] sz, input logic wb, input logic il,
                                     input logic be);
    return {alu, rw, im, inc, rq, we, sz, wb, il, be};
  endfunction

  task automatic check(input logic sel);
    exp_t        x;
    logic [14:0] o;
    #2;
    x = sb.pop_front();
    o = sel ? {b_alu, b_regw, b_imm, b_incr, b_req, b_we, b_sz, b_wb, b_ill, b_be}
            : {a_alu, a_regw, a_imm, a_incr, a_req, a_we, a_sz, a_wb, a_ill, a_be};
    total++;
    assert ((o & x.m) === (x.e & x.m)) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", x.tag, o & x.m, x.e & x.m);
    end
  endtask

  task automatic step(input logic sel, input logic v, input logic [6:0] op, input logic [2:0] f3,
                      input logic [6:0] f7, input logic rdy, input logic clr,
                      input logic [14:0] e, input logic [14:0] m, input string tag);
    @(negedge clock);
    instr_valid = v;
    opcode      = op;
    funct3      = f3;
    funct7      = f7;
    mem_ready   = rdy;
    trap_clr    = clr;
    sb.push_back('{e, m, tag});
    check(sel);
  endtask

  initial begin
    logic [14:0] z, ill, be;
    z   = pk(4'h0, 0, 0, 0, 0, 0, 3'b000, 0, 0, 0);
    ill = pk(4'h0, 0, 0, 0, 0, 0, 3'b000, 0, 1, 0);
    be  = pk(4'h0, 0, 0, 0, 0, 0, 3'b000, 0, 0, 1);

    // Reset holds outputs idle even with a valid instruction presented
    step(0, 1, OP_R, 3'b000, 7'h20, 1, 0, z, ALL, "rst_a");
    step(1, 1, OP_L, 3'b010, 7'h00, 0, 0, z, ALL, "rst_b");
    @(posedge clock); #1 nReset = 1'b1;

    step(0, 1, OP_R, 3'b000, 7'h20, 0, 0, pk(4'b0001, 1, 0, 1, 0, 0, 3'b000, 0, 0, 0), ALL, "ralu_sub");
    step(0, 0, OP_R, 3'b000, 7'h00, 0, 0, z, ALL, "idle");
    step(0, 1, OP_I, 3'b101, 7'h20, 0, 0, pk(4'b1011, 1, 1, 1, 0, 0, 3'b000, 0, 0, 0), ALL, "srai");
    step(0, 1, OP_I, 3'b000, 7'h7F, 0, 0, pk(4'b0000, 1, 1, 1, 0, 0, 3'b000, 0, 0, 0), ALL, "addi_f7");

    step(0, 1, OP_L, 3'b010, 7'h00, 0, 0, pk(4'h0, 0, 1, 0, 1, 0, 3'b000, 0, 0, 0), NO_SZ, "ld_dec");
    step(0, 1, OP_R, 3'b111, 7'h7F, 0, 0, pk(4'h0, 0, 1, 0, 1, 0, 3'b010, 0, 0, 0), ALL, "ld_wait0");
    step(0, 1, OP_R, 3'b111, 7'h7F, 1, 0, pk(4'h0, 0, 1, 0, 1, 0, 3'b010, 0, 0, 0), ALL, "ld_wait1");
    step(0, 0, OP_R, 3'b000, 7'h00, 0, 0, pk(4'h0, 1, 0, 1, 0, 0, 3'b000, 1, 0, 0), ALL, "ld_wb");

    step(0, 1, OP_S, 3'b001, 7'h00, 1, 0, pk(4'h0, 0, 1, 0, 1, 1, 3'b000, 0, 0, 0), NO_SZ, "st_dec");
    step(0, 0, OP_R, 3'b000, 7'h00, 1, 0, pk(4'h0, 0, 1, 1, 1, 1, 3'b001, 0, 0, 0), ALL, "st_done");
    step(0, 0, OP_R, 3'b000, 7'h00, 0, 0, z, ALL, "st_idle");

    step(0, 1, 7'h7F, 3'b000, 7'h00, 0, 0, z, ALL, "badop_dec");
    step(0, 1, OP_R, 3'b000, 7'h00, 0, 0, ill, ALL, "trap_hold0");
    step(0, 0, OP_R, 3'b000, 7'h00, 0, 0, ill, ALL, "trap_hold1");
    step(0, 0, OP_R, 3'b000, 7'h00, 0, 1, ill, ALL, "trap_clr");
    step(0, 0, OP_R, 3'b000, 7'h00, 0, 0, z, ALL, "trap_left");
    step(0, 1, OP_R, 3'b000, 7'h01, 0, 0, z, ALL, "ralu_f7_bad");
    step(0, 0, OP_R, 3'b000, 7'h00, 0, 0, ill, ALL, "trap2");
    step(0, 0, OP_R, 3'b000, 7'h00, 0, 1, ill, ALL, "trap2_clr");
    step(0, 1, OP_R, 3'b111, 7'h00, 0, 0, pk(4'b1110, 1, 0, 1, 0, 0, 3'b000, 0, 0, 0), ALL, "and_after");

    // Timeout instance: counter 0..4 in MEM_WAIT, trap on the fifth stalled cycle
    @(posedge clock); #1 nReset_b = 1'b1;
    step(1, 1, OP_L, 3'b100, 7'h00, 0, 0, pk(4'h0, 0, 1, 0, 1, 0, 3'b000, 0, 0, 0), NO_SZ, "to_dec");
    for (int i = 0; i < 5; i++)
      step(1, 0, OP_R, 3'b000, 7'h00, 0, 0, pk(4'h0, 0, 1, 0, 1, 0, 3'b100, 0, 0, 0), ALL, "to_wait");
    step(1, 0, OP_R, 3'b000, 7'h00, 0, 0, be, ALL, "to_buserr");
    step(1, 0, OP_R, 3'b000, 7'h00, 1, 0, be, ALL, "to_trap_hold");
    step(1, 0, OP_R, 3'b000, 7'h00, 0, 1, be, ALL, "to_clr");
    step(1, 0, OP_R, 3'b000, 7'h00, 0, 0, z, ALL, "to_left");

    // Asynchronous reset in the middle of a stalled load
    step(1, 1, OP_L, 3'b000, 7'h00, 0, 0, pk(4'h0, 0, 1, 0, 1, 0, 3'b000, 0, 0, 0), NO_SZ, "rst_ld_dec");
    step(1, 0, OP_R, 3'b000, 7'h00, 0, 0, pk(4'h0, 0, 1, 0, 1, 0, 3'b000, 0, 0, 0), ALL, "rst_ld_wait");
    @(negedge clock);
    #1 nReset_b = 1'b0;
    sb.push_back('{z, ALL, "rst_async"});
    check(1);
    @(posedge clock); #1 nReset_b = 1'b1;
    step(1, 1, OP_R, 3'b000, 7'h00, 0, 0, pk(4'b0000, 1, 0, 1, 0, 0, 3'b000, 0, 0, 0), ALL, "post_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
